time_keeper: RTL and testbench

Seconds/minutes/hours timekeeping stage of the digital clock. Consumes the divided clock produced by the clock divider (sampled as a level in the `clk_in` domain), advances a 24-hour HH:MM:SS count on each detected tick, and presents the time as packed BCD to the display stage. It also supports a validated time-load (set) interface and a run/pause control.

---
 rtl/time_keeper.sv | 223 ++++++++++++++++++++++
 tb/tb_time_keeper.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// -----------------------------------------------------------------------------
// time_keeper
//
// 24-hour HH:MM:SS timekeeping stage. The divided clock from the clock divider
// is sampled as a level in the clk_in domain. Each qualifying edge, while run is
// high, advances six directly stored BCD digits. A validated set interface loads
// a new time, converting the binary fields to BCD.
//
// Parameters
//   TICK_EDGES : 1 = advance on rising edges of tick_in only,
//                2 = advance on both rising and falling edges.
//
// Ports
//   clk_in    in  1  main clock, all registers on rising edge
//   rst       in  1  synchronous active-high reset
//   tick_in   in  1  divided clock level (already in clk_in domain)
//   run       in  1  1 = ticks advance time, 0 = ticks discarded
//   set_valid in  1  one-cycle request to load set_hr/set_min/set_sec
//   set_hr    in  5  binary hours to load (0-23)
//   set_min   in  6  binary minutes to load (0-59)
//   set_sec   in  6  binary seconds to load (0-59)
//   hr_bcd    out 8  hours   {tens, units} BCD
//   min_bcd   out 8  minutes {tens, units} BCD
//   sec_bcd   out 8  seconds {tens, units} BCD
//   sec_pulse out 1  one-cycle pulse on every tick
//   min_roll  out 1  one-cycle pulse when seconds wrap 59 -> 00
//   day_roll  out 1  one-cycle pulse when time wraps 23:59:59 -> 00:00:00
//   set_err   out 1  one-cycle pulse when a set request is rejected
// -----------------------------------------------------------------------------
module time_keeper #(
   parameter int TICK_EDGES = 1
) (
   input  logic       clk_in,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       run,
   input  logic       set_valid,
   input  logic [4:0] set_hr,
   input  logic [5:0] set_min,
   input  logic [5:0] set_sec,
   output logic [7:0] hr_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       sec_pulse,
   output logic       min_roll,
   output logic       day_roll,
   output logic       set_err
);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic       tick_d_reg;

   logic [3:0] s0_reg, s0_next;
   logic [3:0] s1_reg, s1_next;
   logic [3:0] m0_reg, m0_next;
   logic [3:0] m1_reg, m1_next;
   logic [3:0] h0_reg, h0_next;
   logic [3:0] h1_reg, h1_next;

   logic       sec_pulse_reg, sec_pulse_next;
   logic       min_roll_reg,  min_roll_next;
   logic       day_roll_reg,  day_roll_next;
   logic       set_err_reg,   set_err_next;

   // ---------------------------------------------------------------------------
   // Edge detection
   // ---------------------------------------------------------------------------
   logic rise_edge;
   logic fall_edge;
   logic edge_det;

   assign rise_edge = tick_in & ~tick_d_reg;
   assign fall_edge = ~tick_in & tick_d_reg;

   generate
      if (TICK_EDGES == 2) begin : g_both_edges
         assign edge_det = rise_edge | fall_edge;
      end else begin : g_rise_only
         assign edge_det = rise_edge;
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Set validation and binary -> BCD conversion of the set fields.
   // Index 0 = seconds, 1 = minutes, 2 = hours (zero-extended to 6 bits).
   // ---------------------------------------------------------------------------
   logic       set_ok;
   logic       set_bad;
   logic [5:0] set_field [3];
   logic [3:0] set_tens  [3];
   logic [3:0] set_units [3];

   assign set_ok  = set_valid && (set_hr <= 5'd23) && (set_min <= 6'd59)
                    && (set_sec <= 6'd59);
   assign set_bad = set_valid && !set_ok;

   assign set_field[0] = set_sec;
   assign set_field[1] = set_min;
   assign set_field[2] = {1'b0, set_hr};

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_set_bcd
         assign set_tens[gi]  = 4'(set_field[gi] / 6'd10);
         assign set_units[gi] = 4'(set_field[gi] % 6'd10);
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Tick qualification: an accepted set takes priority and swallows the tick,
   // a rejected set does not.
   // ---------------------------------------------------------------------------
   logic tick;
   logic sec_wrap;
   logic min_wrap;
   logic hr_last;

   assign tick     = edge_det && run && !set_ok;
   assign sec_wrap = (s1_reg == 4'd5) && (s0_reg == 4'd9);
   assign min_wrap = (m1_reg == 4'd5) && (m0_reg == 4'd9);
   assign hr_last  = (h1_reg == 4'd2) && (h0_reg == 4'd3);

   // ---------------------------------------------------------------------------
   // Next-state logic for the digits and pulses
   // ---------------------------------------------------------------------------
   always_comb begin
      s0_next = s0_reg;
      s1_next = s1_reg;
      m0_next = m0_reg;
      m1_next = m1_reg;
      h0_next = h0_reg;
      h1_next = h1_reg;

      if (set_ok) begin
         s0_next = set_units[0];
         s1_next = set_tens[0];
         m0_next = set_units[1];
         m1_next = set_tens[1];
         h0_next = set_units[2];
         h1_next = set_tens[2];
      end else if (tick) begin
         // Seconds
         if (s0_reg == 4'd9) begin
            s0_next = 4'd0;
            s1_next = (s1_reg == 4'd5) ? 4'd0 : s1_reg + 4'd1;
         end else begin
            s0_next = s0_reg + 4'd1;
         end

         // Minutes ripple only on the seconds 59 -> 00 wrap
         if (sec_wrap) begin
            if (m0_reg == 4'd9) begin
               m0_next = 4'd0;
               m1_next = (m1_reg == 4'd5) ? 4'd0 : m1_reg + 4'd1;
            end else begin
               m0_next = m0_reg + 4'd1;
            end
         end

         // Hours ripple on the mm:ss 59:59 wrap; 23 wraps to 00
         if (sec_wrap && min_wrap) begin
            if (hr_last) begin
               h0_next = 4'd0;
               h1_next = 4'd0;
            end else if (h0_reg == 4'd9) begin
               h0_next = 4'd0;
               h1_next = h1_reg + 4'd1;
            end else begin
               h0_next = h0_reg + 4'd1;
            end
         end
      end
   end

   always_comb begin
      sec_pulse_next = tick;
      min_roll_next  = tick && sec_wrap;
      day_roll_next  = tick && sec_wrap && min_wrap && hr_last;
      set_err_next   = set_bad;
   end

   // ---------------------------------------------------------------------------
   // Registers. tick_d follows tick_in even in reset so the first cycle after
   // reset never sees a spurious edge.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_in) begin
      tick_d_reg <= tick_in;
      if (rst) begin
         s0_reg        <= 4'd0;
         s1_reg        <= 4'd0;
         m0_reg        <= 4'd0;
         m1_reg        <= 4'd0;
         h0_reg        <= 4'd0;
         h1_reg        <= 4'd0;
         sec_pulse_reg <= 1'b0;
         min_roll_reg  <= 1'b0;
         day_roll_reg  <= 1'b0;
         set_err_reg   <= 1'b0;
      end else begin
         s0_reg        <= s0_next;
         s1_reg        <= s1_next;
         m0_reg        <= m0_next;
         m1_reg        <= m1_next;
         h0_reg        <= h0_next;
         h1_reg        <= h1_next;
         sec_pulse_reg <= sec_pulse_next;
         min_roll_reg  <= min_roll_next;
         day_roll_reg  <= day_roll_next;
         set_err_reg   <= set_err_next;
      end
   end

   assign hr_bcd    = {h1_reg, h0_reg};
   assign min_bcd   = {m1_reg, m0_reg};
   assign sec_bcd   = {s1_reg, s0_reg};
   assign sec_pulse = sec_pulse_reg;
   assign min_roll  = min_roll_reg;
   assign day_roll  = day_roll_reg;
   assign set_err   = set_err_reg;

endmodule

// File: tb/tb_time_keeper.sv
// -----------------------------------------------------------------------------
// tb_time_keeper
//
// Drives two time_keeper instances (rising-only and both-edge) from the same
// stimulus. A reference model tracks time as seconds-of-day and derives the
// expected BCD and pulse values arithmetically.
// -----------------------------------------------------------------------------
module tb_time_keeper;

   logic       clk_in = 1'b0;
   logic       rst = 1'b1;
   logic       tick_in = 1'b0;
   logic       run = 1'b1;
   logic       set_valid = 1'b0;
   logic [4:0] set_hr = '0;
   logic [5:0] set_min = '0;
   logic [5:0] set_sec = '0;

   logic [7:0] hr1, min1, sec1, hr2, min2, sec2;
   logic       sp1, mr1, dr1, er1, sp2, mr2, dr2, er2;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk_in = ~clk_in;

   time_keeper #(.TICK_EDGES(1)) dut1 (
      .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .run(run),
      .set_valid(set_valid), .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
      .hr_bcd(hr1), .min_bcd(min1), .sec_bcd(sec1),
      .sec_pulse(sp1), .min_roll(mr1), .day_roll(dr1), .set_err(er1)
   );

   time_keeper #(.TICK_EDGES(2)) dut2 (
      .clk_in(clk_in), .rst(rst), .tick_in(tick_in), .run(run),
      .set_valid(set_valid), .set_hr(set_hr), .set_min(set_min), .set_sec(set_sec),
      .hr_bcd(hr2), .min_bcd(min2), .sec_bcd(sec2),
      .sec_pulse(sp2), .min_roll(mr2), .day_roll(dr2), .set_err(er2)
   );

   // ---------------------------------------------------------------------------
   // Reference model: time of day as an integer number of seconds
   // ---------------------------------------------------------------------------
   int   m_tod1 = 0, m_tod2 = 0;
   logic m_prev = 1'b0;
   logic m_sp1 = 0, m_mr1 = 0, m_dr1 = 0, m_sp2 = 0, m_mr2 = 0, m_dr2 = 0, m_err = 0;

   always @(posedge clk_in) begin : model
      logic rise, fall, ok, t1, t2;
      rise = tick_in && !m_prev;
      fall = !tick_in && m_prev;
      ok   = set_valid && (set_hr <= 23) && (set_min <= 59) && (set_sec <= 59);
      t1   = rise && run && !ok;
      t2   = (rise || fall) && run && !ok;
      m_prev <= tick_in;
      if (rst) begin
         m_tod1 <= 0; m_tod2 <= 0;
         m_sp1 <= 0; m_mr1 <= 0; m_dr1 <= 0;
         m_sp2 <= 0; m_mr2 <= 0; m_dr2 <= 0;
         m_err <= 0;
      end else begin
         m_err <= set_valid && !ok;
         m_sp1 <= t1;
         m_mr1 <= t1 && (m_tod1 % 60 == 59);
         m_dr1 <= t1 && (m_tod1 == 86399);
         m_sp2 <= t2;
         m_mr2 <= t2 && (m_tod2 % 60 == 59);
         m_dr2 <= t2 && (m_tod2 == 86399);
         if (ok) begin
            m_tod1 <= int'(set_hr) * 3600 + int'(set_min) * 60 + int'(set_sec);
            m_tod2 <= int'(set_hr) * 3600 + int'(set_min) * 60 + int'(set_sec);
         end else begin
            if (t1) m_tod1 <= (m_tod1 + 1) % 86400;
            if (t2) m_tod2 <= (m_tod2 + 1) % 86400;
         end
      end
   end

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) + (v % 10));
   endfunction

   function automatic logic [23:0] tod_bcd(input int tod);
      return {to_bcd(tod / 3600), to_bcd((tod / 60) % 60), to_bcd(tod % 60)};
   endfunction

   // One clock: inputs already applied at the falling edge, outputs settled at
   // the next falling edge.
   task automatic drive(input logic t, input logic sv, input int h, input int m, input int s);
      tick_in   = t;
      set_valid = sv;
      set_hr    = 5'(h);
      set_min   = 6'(m);
      set_sec   = 6'(s);
      @(posedge clk_in);
      @(negedge clk_in);
      set_valid = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset;
      rst = 1'b1;
      drive(1'b1, 1'b0, 0, 0, 0);
      drive(1'b1, 1'b0, 0, 0, 0);
      drive(1'b1, 1'b0, 0, 0, 0);
      n_vec++;
      if ({hr1, min1, sec1, sp1, mr1, dr1, er1} !== 28'h0) begin
         n_err++;
         $display("FAIL reset_dut1 got %h want 0", {hr1, min1, sec1, sp1, mr1, dr1, er1});
      end
      n_vec++;
      if ({hr2, min2, sec2, sp2, mr2, dr2, er2} !== 28'h0) begin
         n_err++;
         $display("FAIL reset_dut2 got %h want 0", {hr2, min2, sec2, sp2, mr2, dr2, er2});
      end
      rst = 1'b0;
      drive(1'b1, 1'b0, 0, 0, 0);
      n_vec++;
      if ({sp1, sp2} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_first_cycle sec_pulse got %b want 00", {sp1, sp2});
      end
      drive(1'b0, 1'b0, 0, 0, 0);
      $display("test_reset done: time %h:%h:%h", hr1, min1, sec1);
   endtask

   task automatic test_count;
      for (int i = 1; i <= 61; i++) begin
         drive(1'b1, 1'b0, 0, 0, 0);
         n_vec++;
         if ({hr1, min1, sec1, sp1, mr1} !== {tod_bcd(i), 1'b1, 1'(i == 60)}) begin
            n_err++;
            $display("FAIL count_edge%0d got %h %b%b want %h 1%b",
                     i, {hr1, min1, sec1}, sp1, mr1, tod_bcd(i), (i == 60));
         end
         if (i == 1 || i == 60) begin
            n_vec++;
            if ({min1, sec1} !== ((i == 1) ? 16'h0001 : 16'h0100)) begin
               n_err++;
               $display("FAIL count_fixed%0d got %h", i, {min1, sec1});
            end
         end
         drive(1'b0, 1'b0, 0, 0, 0);
         n_vec++;
         if ({sp1, mr1} !== 2'b00) begin
            n_err++;
            $display("FAIL count_pulse_width%0d got %b want 00", i, {sp1, mr1});
         end
      end
      // Jump close to midnight and finish the day
      drive(1'b0, 1'b1, 23, 59, 50);
      for (int i = 1; i <= 10; i++) begin
         drive(1'b1, 1'b0, 0, 0, 0);
         n_vec++;
         if ({hr1, min1, sec1, dr1} !== {tod_bcd((86390 + i) % 86400), 1'(i == 10)}) begin
            n_err++;
            $display("FAIL day_edge%0d got %h dr=%b want %h dr=%b",
                     i, {hr1, min1, sec1}, dr1, tod_bcd((86390 + i) % 86400), (i == 10));
         end
         drive(1'b0, 1'b0, 0, 0, 0);
      end
      $display("test_count done: time %h:%h:%h", hr1, min1, sec1);
   endtask

   task automatic test_set;
      drive(1'b0, 1'b1, 23, 59, 58);
      n_vec++;
      if ({hr1, min1, sec1} !== 24'h235958) begin
         n_err++;
         $display("FAIL set_load got %h want 235958", {hr1, min1, sec1});
      end
      drive(1'b1, 1'b0, 0, 0, 0);
      drive(1'b0, 1'b0, 0, 0, 0);
      drive(1'b1, 1'b0, 0, 0, 0);
      n_vec++;
      if ({hr1, min1, sec1, dr1, mr1} !== {24'h000000, 2'b11}) begin
         n_err++;
         $display("FAIL set_wrap got %h dr=%b mr=%b want 000000 1 1", {hr1, min1, sec1}, dr1, mr1);
      end
      drive(1'b0, 1'b0, 0, 0, 0);
      drive(1'b0, 1'b1, 24, 0, 0);
      n_vec++;
      if ({er1, hr1, min1, sec1} !== {1'b1, 24'h000000}) begin
         n_err++;
         $display("FAIL set_hr24 got err=%b %h want 1 000000", er1, {hr1, min1, sec1});
      end
      drive(1'b0, 1'b1, 5, 6, 60);
      n_vec++;
      if ({er1, er2, hr1, min1, sec1} !== {2'b11, 24'h000000}) begin
         n_err++;
         $display("FAIL set_sec60 got err=%b%b %h want 11 000000", er1, er2, {hr1, min1, sec1});
      end
      drive(1'b0, 1'b0, 0, 0, 0);
      n_vec++;
      if (er1 !== 1'b0) begin
         n_err++;
         $display("FAIL set_err_width got %b want 0", er1);
      end
      $display("test_set done: time %h:%h:%h", hr1, min1, sec1);
   endtask

   task automatic test_simultaneous;
      drive(1'b1, 1'b1, 12, 34, 56);
      n_vec++;
      if ({hr1, min1, sec1, sp1, sp2} !== {24'h123456, 2'b00}) begin
         n_err++;
         $display("FAIL simul_accept got %h sp=%b%b want 123456 00", {hr1, min1, sec1}, sp1, sp2);
      end
      drive(1'b0, 1'b0, 0, 0, 0);
      drive(1'b1, 1'b1, 1, 2, 60);
      n_vec++;
      if ({hr1, min1, sec1, sp1, er1} !== {24'h123457, 2'b11}) begin
         n_err++;
         $display("FAIL simul_reject got %h sp=%b err=%b want 123457 1 1", {hr1, min1, sec1}, sp1, er1);
      end
      drive(1'b0, 1'b0, 0, 0, 0);
      $display("test_simultaneous done: time %h:%h:%h", hr1, min1, sec1);
   endtask

   task automatic test_pause;
      logic [23:0] snap;
      logic        seen;
      snap = {hr1, min1, sec1};
      seen = 1'b0;
      run  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 0, 0, 0);
         seen = seen | sp1 | sp2;
         drive(1'b0, 1'b0, 0, 0, 0);
         seen = seen | sp1 | sp2;
      end
      n_vec++;
      if ({hr1, min1, sec1, seen} !== {snap, 1'b0}) begin
         n_err++;
         $display("FAIL pause got %h pulse=%b want %h 0", {hr1, min1, sec1}, seen, snap);
      end
      run = 1'b1;
      drive(1'b0, 1'b0, 0, 0, 0);
      n_vec++;
      if ({hr1, min1, sec1} !== snap) begin
         n_err++;
         $display("FAIL pause_no_catchup got %h want %h", {hr1, min1, sec1}, snap);
      end
      $display("test_pause done: time %h:%h:%h", hr1, min1, sec1);
   endtask

   task automatic test_both_edges;
      drive(1'b0, 1'b1, 0, 0, 0);
      drive(1'b1, 1'b0, 0, 0, 0);
      drive(1'b0, 1'b0, 0, 0, 0);
      drive(1'b1, 1'b0, 0, 0, 0);
      drive(1'b0, 1'b0, 0, 0, 0);
      n_vec++;
      if ({sec2, sec1} !== 16'h0402) begin
         n_err++;
         $display("FAIL both_edges got dut2=%h dut1=%h want 04 02", sec2, sec1);
      end
      $display("test_both_edges done: dut1 %h dut2 %h", sec1, sec2);
   endtask

   task automatic test_reset_mid;
      drive(1'b0, 1'b1, 1, 2, 2);
      drive(1'b1, 1'b0, 0, 0, 0);
      n_vec++;
      if ({hr1, min1, sec1} !== 24'h010203) begin
         n_err++;
         $display("FAIL reset_mid_pre got %h want 010203", {hr1, min1, sec1});
      end
      drive(1'b0, 1'b0, 0, 0, 0);
      rst = 1'b1;
      drive(1'b1, 1'b1, 3, 3, 3);
      rst = 1'b0;
      n_vec++;
      if ({hr1, min1, sec1, sp1, mr1, dr1, er1, hr2, min2, sec2, sp2} !== 53'h0) begin
         n_err++;
         $display("FAIL reset_mid got %h %b / %h %b want zeros",
                  {hr1, min1, sec1}, {sp1, mr1, dr1, er1}, {hr2, min2, sec2}, sp2);
      end
      drive(1'b1, 1'b0, 0, 0, 0);
      n_vec++;
      if ({sp1, sec1} !== 9'h0) begin
         n_err++;
         $display("FAIL reset_mid_after got sp=%b sec=%h want 0 00", sp1, sec1);
      end
      drive(1'b0, 1'b0, 0, 0, 0);
      $display("test_reset_mid done: time %h:%h:%h", hr1, min1, sec1);
   endtask

   task automatic test_random;
      int bad;
      bad = 0;
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         run = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 499) == 0) begin
            drive($urandom_range(0, 1) == 1, 1'b1, 23, 59, $urandom_range(50, 59));
         end else begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 63));
         end
         n_vec++;
         if ({hr1, min1, sec1, sp1, mr1, dr1, er1} !==
             {tod_bcd(m_tod1), m_sp1, m_mr1, m_dr1, m_err}) begin
            n_err++; bad++;
            $display("FAIL random_dut1 cycle %0d got %h %b want %h %b", i, {hr1, min1, sec1},
                     {sp1, mr1, dr1, er1}, tod_bcd(m_tod1), {m_sp1, m_mr1, m_dr1, m_err});
         end
         n_vec++;
         if ({hr2, min2, sec2, sp2, mr2, dr2, er2} !==
             {tod_bcd(m_tod2), m_sp2, m_mr2, m_dr2, m_err}) begin
            n_err++; bad++;
            $display("FAIL random_dut2 cycle %0d got %h %b want %h %b", i, {hr2, min2, sec2},
                     {sp2, mr2, dr2, er2}, tod_bcd(m_tod2), {m_sp2, m_mr2, m_dr2, m_err});
         end
      end
      rst = 1'b0;
      run = 1'b1;
      $display("test_random done: %0d bad cycles", bad);
   endtask

   initial begin
      @(negedge clk_in);
      test_reset();
      test_count();
      test_set();
      test_simultaneous();
      test_pause();
      test_both_edges();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
